// File: rtl/adc_responder.sv
// SPI responder twin of a 4-channel 12-bit MCP3204-class ADC.
// Decodes start/SGL/D2..D0 from MOSI, latches one channel, returns null bit then data MSB-first.
module adc_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CS,
  input  logic                  P3,
  input  logic                  P5,
  output logic                  P4,
  output logic                  P4_oe,
  input  logic [4*DATA_W-1:0]   ch_data,
  output logic                  sgl,
  output logic [2:0]            chan,
  output logic                  conv_start,
  output logic                  done,
  output logic                  abort
);

  localparam int unsigned IW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CTRL, S_SAMPLE, S_NULL_BIT, S_DATA, S_TRAIL
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] p3_sync_q, p3_sync_d;
  logic [SYNC_STAGES-1:0] p5_sync_q, p5_sync_d;
  logic                   p3_prev_q, p3_prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   cs_s, p3_s, p5_s;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [2:0]             ctrl_q, ctrl_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]      snap_q, snap_d;
  logic                   p4_q, p4_d;
  logic                   oe_q, oe_d;
  logic                   sgl_q, sgl_d;
  logic [2:0]             chan_q, chan_d;
  logic                   conv_q, conv_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic [1:0]             sel;
  logic [DATA_W-1:0]      snap_sel;

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign p3_s = p3_sync_q[SYNC_STAGES-1];
  assign p5_s = p5_sync_q[SYNC_STAGES-1];

  // Edge events are registered so P4 moves SYNC_STAGES+2 clk after the P3 pin.
  always_comb begin
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], CS};
    p3_sync_d = {p3_sync_q[SYNC_STAGES-2:0], P3};
    p5_sync_d = {p5_sync_q[SYNC_STAGES-2:0], P5};
    p3_prev_d = p3_s;
    rise_d    = p3_s & ~p3_prev_q;
    fall_d    = ~p3_s & p3_prev_q;
  end

  // Channel select uses D1 (already shifted in) and D0 (arriving now); D2 is ignored.
  always_comb begin
    sel      = {ctrl_q[0], p5_s};
    snap_sel = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      if (sel == n[1:0]) snap_sel = ch_data[n*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    p4_d    = p4_q;
    oe_d    = oe_q;
    sgl_d   = sgl_q;
    chan_d  = chan_q;
    conv_d  = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;

    if (state_q != S_IDLE && cs_s) begin
      state_d = S_IDLE;
      p4_d    = 1'b0;
      oe_d    = 1'b0;
      abort_d = (state_q == S_CTRL) || (state_q == S_SAMPLE) ||
                (state_q == S_NULL_BIT) || (state_q == S_DATA);
    end else begin
      case (state_q)
        S_IDLE: begin
          p4_d = 1'b0;
          oe_d = 1'b0;
          if (!cs_s) state_d = S_WAIT_START;
        end
        S_WAIT_START: begin
          if (rise_q && p5_s) begin
            state_d = S_CTRL;
            cnt_d   = '0;
          end
        end
        S_CTRL: begin
          if (rise_q) begin
            ctrl_d = {ctrl_q[1:0], p5_s};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              sgl_d   = ctrl_q[2];
              chan_d  = {ctrl_q[1:0], p5_s};
              snap_d  = snap_sel;
              conv_d  = 1'b1;
              state_d = S_SAMPLE;
            end
          end
        end
        S_SAMPLE: begin
          if (rise_q) state_d = S_NULL_BIT;
        end
        S_NULL_BIT: begin
          if (fall_q) begin
            p4_d    = 1'b0;
            oe_d    = 1'b1;
            idx_d   = IW'(DATA_W - 1);
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (fall_q) begin
            p4_d  = snap_q[idx_q];
            idx_d = idx_q - 1'b1;
            if (idx_q == '0) begin
              done_d  = 1'b1;
              state_d = S_TRAIL;
            end
          end
        end
        S_TRAIL: begin
          if (fall_q) p4_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync_q <= '1;
      p3_sync_q <= '0;
      p5_sync_q <= '0;
      p3_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      p4_q      <= 1'b0;
      oe_q      <= 1'b0;
      sgl_q     <= 1'b0;
      chan_q    <= '0;
      conv_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      cs_sync_q <= cs_sync_d;
      p3_sync_q <= p3_sync_d;
      p5_sync_q <= p5_sync_d;
      p3_prev_q <= p3_prev_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      p4_q      <= p4_d;
      oe_q      <= oe_d;
      sgl_q     <= sgl_d;
      chan_q    <= chan_d;
      conv_q    <= conv_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign P4         = p4_q & oe_q;
  assign P4_oe      = oe_q;
  assign sgl        = sgl_q;
  assign chan       = chan_q;
  assign conv_start = conv_q;
  assign done       = done_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_adc_responder.sv
// Self-checking bench for adc_responder: acts as SPI master, compares MISO against a frame-level model.
module tb_adc_responder;

  localparam int unsigned SS = 2;
  localparam int unsigned DW = 12;
  localparam int unsigned H  = 20;

  localparam int MODE_FULL  = 0;
  localparam int MODE_ABORT = 1;
  localparam int MODE_RESET = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            CS, P3, P5;
  logic            P4, P4_oe;
  logic [4*DW-1:0] ch_data;
  logic            sgl;
  logic [2:0]      chan;
  logic            conv_start, done, abort;

  int unsigned n_vec = 0, n_err = 0;
  int unsigned conv_cnt = 0, done_cnt = 0, abort_cnt = 0;
  bit          mut_req = 1'b0, mut_pend = 1'b0;

  adc_responder #(.SYNC_STAGES(SS), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .CS(CS), .P3(P3), .P5(P5), .P4(P4), .P4_oe(P4_oe),
    .ch_data(ch_data), .sgl(sgl), .chan(chan), .conv_start(conv_start),
    .done(done), .abort(abort)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (conv_start) conv_cnt++;
    if (done)       done_cnt++;
    if (abort)      abort_cnt++;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clock wait; optionally perturbs ch_data one clk after conv_start is seen.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (mut_pend) begin
        ch_data  = ~ch_data;
        mut_pend = 1'b0;
      end else if (mut_req && conv_start) begin
        mut_pend = 1'b1;
        mut_req  = 1'b0;
      end
    end
  endtask

  task automatic spi_bit(input bit mosi, output bit miso, output bit oe);
    P5 = mosi;
    tick(5);
    P3 = 1'b1;
    tick(H);
    P3 = 1'b0;
    tick(H);
    miso = P4;
    oe   = P4_oe;
  endtask

  function automatic logic [4*DW-1:0] rand_data();
    logic [4*DW-1:0] d;
    for (int i = 0; i < 4; i++) d[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
    return d;
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [4*DW-1:0] d, input int c);
    logic [4*DW-1:0] t;
    t = d >> ((c % 4) * DW);
    return t[DW-1:0];
  endfunction

  task automatic run_frame(input int lead, input bit s, input logic [2:0] c,
                           input int mode, input int stop_after, input bit mutate);
    logic [DW-1:0] w;
    bit            q[$];
    bit            m, o;
    int unsigned   c0, d0, a0;
    c0 = conv_cnt; d0 = done_cnt; a0 = abort_cnt;
    w  = word_of(ch_data, int'(c));
    q.push_back(1'b0);
    for (int i = DW - 1; i >= 0; i--) q.push_back(w[i]);
    q.push_back(1'b0);
    q.push_back(1'b0);

    CS = 1'b0;
    tick(8);
    for (int i = 0; i < lead; i++) begin
      spi_bit(1'b0, m, o);
      chk("lead_oe", o, 0);
    end
    spi_bit(1'b1, m, o);
    chk("start_oe", o, 0);
    spi_bit(s, m, o);
    spi_bit(c[2], m, o);
    spi_bit(c[1], m, o);
    mut_req = mutate;
    spi_bit(c[0], m, o);
    chk("ctrl_oe", o, 0);
    chk("conv_once", conv_cnt, c0 + 1);
    chk("sgl", sgl, s);
    chk("chan", chan, c);

    for (int k = 0; k < q.size(); k++) begin
      if (mode != MODE_FULL && k == stop_after + 1) break;
      spi_bit(1'($urandom_range(0, 1)), m, o);
      chk($sformatf("miso[%0d]", k), m, q[k]);
      chk($sformatf("oe[%0d]", k), o, 1);
    end

    if (mode == MODE_FULL) begin
      chk("done_once", done_cnt, d0 + 1);
      CS = 1'b1;
      tick(6);
      chk("end_oe", P4_oe, 0);
      chk("end_miso", P4, 0);
      chk("no_abort", abort_cnt, a0);
      chk("conv_total", conv_cnt, c0 + 1);
    end else if (mode == MODE_ABORT) begin
      CS = 1'b1;
      tick(4);
      chk("abort_once", abort_cnt, a0 + 1);
      chk("abort_oe", P4_oe, 0);
      chk("abort_miso", P4, 0);
      chk("abort_nodone", done_cnt, d0);
      tick(4);
    end else begin
      rst = 1'b0;
      tick(2);
      chk("rst_miso", P4, 0);
      chk("rst_oe", P4_oe, 0);
      chk("rst_sgl", sgl, 0);
      chk("rst_chan", chan, 0);
      chk("rst_pulses", {conv_start, done, abort}, 0);
      rst = 1'b1;
      CS  = 1'b1;
      tick(10);
      chk("rst_noabort", abort_cnt, a0);
      chk("rst_nodone", done_cnt, d0);
    end
    tick(10);
  endtask

  initial begin
    rst = 1'b0; CS = 1'b1; P3 = 1'b0; P5 = 1'b0; ch_data = '0;
    tick(3);
    chk("reset_outs", {P4, P4_oe, conv_start, done, abort}, 0);
    chk("reset_sgl_chan", {sgl, chan}, 0);
    rst = 1'b1;
    tick(100);
    chk("idle_outs", {P4, P4_oe, conv_start, done, abort}, 0);
    chk("idle_pulse_counts", conv_cnt + done_cnt + abort_cnt, 0);

    ch_data = rand_data();
    ch_data[0 +: DW] = 12'hA5C;
    run_frame(0, 1'b1, 3'd0, MODE_FULL, 0, 1'b0);

    ch_data[3*DW +: DW] = 12'h0F1;
    run_frame(0, 1'b1, 3'd7, MODE_FULL, 0, 1'b0);

    ch_data[1*DW +: DW] = 12'hFFF;
    run_frame(3, 1'b1, 3'd1, MODE_FULL, 0, 1'b0);

    run_frame(0, 1'b0, 3'd2, MODE_ABORT, 5, 1'b0);
    ch_data[2*DW +: DW] = 12'h123;
    run_frame(0, 1'b1, 3'd2, MODE_FULL, 0, 1'b0);

    ch_data = rand_data();
    run_frame(1, 1'b0, 3'($urandom_range(0, 7)), MODE_FULL, 0, 1'b1);

    ch_data = rand_data();
    run_frame(0, 1'b1, 3'd6, MODE_RESET, 4, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ch_data = rand_data();
      run_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), MODE_FULL, 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
